// File: rtl/div_ratio_checker_if.sv
// Signal bundle between a divided-clock source and its ratio checker.
// Both directions of status are grouped so a bench or a parent block can attach with one port.
interface div_ratio_checker_if #(
    parameter int CNT_W = 8
);
    logic             fdiv_in;
    logic             enable;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             error;

    modport master (
        output fdiv_in,
        output enable,
        input  period,
        input  period_valid,
        input  locked,
        input  error
    );

    modport slave (
        input  fdiv_in,
        input  enable,
        output period,
        output period_valid,
        output locked,
        output error
    );
endinterface

// File: rtl/div_ratio_checker.sv
// Measures the fdiv_in period in clk cycles and checks it against DIV +/- TOL; reports lock, mismatch and timeout.
// Latency: outputs update 1 clk after the internal edge pulse, which fires ~3 clk after fdiv_in rises.
// Backpressure: none, free-running monitor. Define DIV_CHK_STICKY_ERR_EN to hold error until enable=0 or reset.
module div_ratio_checker #(
    parameter int DIV        = 8,
    parameter int CNT_W      = 8,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    div_ratio_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE} state_t;

    // Bounds kept one bit wider than the counter so DIV+TOL cannot wrap.
    localparam int               LO_I    = (TOL > DIV) ? 0 : DIV - TOL;
    localparam int               HI_I    = DIV + TOL;
    localparam logic [CNT_W:0]   LO      = LO_I[CNT_W:0];
    localparam logic [CNT_W:0]   HI      = HI_I[CNT_W:0];
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       LC      = LOCK_COUNT[3:0];

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, edge_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] period_q, period_d;
    logic [3:0]       mc_q, mc_d, mc_inc;
    logic             pv_q, pv_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             e, sat, in_range, bad;

    assign e        = sync2_q & ~edge_q;
    assign sat      = (cnt_q == CNT_MAX);
    assign cnt_inc  = sat ? cnt_q : cnt_q + CNT_W'(1);
    assign mc_inc   = (mc_q == LC) ? LC : mc_q + 4'd1;
    // A saturated count is never a match, even if DIV+TOL reaches all-ones.
    assign in_range = !sat && ({1'b0, cnt_q} >= LO) && ({1'b0, cnt_q} <= HI);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            edge_q   <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            mc_q     <= 4'd0;
            period_q <= '0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync1_q  <= bus.fdiv_in;
            sync2_q  <= sync1_q;
            edge_q   <= sync2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mc_q     <= mc_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mc_d     = mc_q;
        period_d = period_q;
        pv_d     = 1'b0;
        locked_d = locked_q;
        bad      = 1'b0;
        if (!bus.enable) begin
            state_d  = IDLE;
            cnt_d    = '0;
            mc_d     = 4'd0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d    = '0;
                    mc_d     = 4'd0;
                    locked_d = 1'b0;
                    state_d  = ACQUIRE;
                end
                ACQUIRE: begin
                    if (e) begin
                        cnt_d   = CNT_W'(1);
                        state_d = MEASURE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                MEASURE: begin
                    if (e) begin
                        cnt_d    = CNT_W'(1);
                        period_d = cnt_q;
                        pv_d     = 1'b1;
                        if (in_range) begin
                            mc_d     = mc_inc;
                            locked_d = (mc_inc == LC);
                        end else begin
                            mc_d     = 4'd0;
                            locked_d = 1'b0;
                            bad      = 1'b1;
                        end
                    end else if (sat) begin
                        // Edge lost: report the saturated count and re-acquire.
                        period_d = cnt_q;
                        pv_d     = 1'b1;
                        mc_d     = 4'd0;
                        locked_d = 1'b0;
                        bad      = 1'b1;
                        state_d  = ACQUIRE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef DIV_CHK_STICKY_ERR_EN
        err_d = bus.enable & (err_q | bad);
`else
        err_d = bad;
`endif
    end

    assign bus.period       = period_q;
    assign bus.period_valid = pv_q;
    assign bus.locked       = locked_q;
    assign bus.error        = err_q;
endmodule

// File: tb/tb_div_ratio_checker.sv
// Random-period bench for div_ratio_checker: two instances (TOL=0 and TOL=1) share one fdiv_in,
// each compared every cycle against a reference built from edge timestamps.
module tb_div_ratio_checker;
    localparam int NI   = 2;
    localparam int MAXC = 255;
    localparam int MIDLE = 0, MACQ = 1, MMEAS = 2;
`ifdef DIV_CHK_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic fdiv;
    logic en;

    int n_checks = 0;
    int n_errors = 0;

    div_ratio_checker_if #(.CNT_W(8)) bus0 ();
    div_ratio_checker_if #(.CNT_W(8)) bus1 ();

    assign bus0.fdiv_in = fdiv;
    assign bus0.enable  = en;
    assign bus1.fdiv_in = fdiv;
    assign bus1.enable  = en;

    div_ratio_checker #(.DIV(8), .CNT_W(8), .TOL(0), .LOCK_COUNT(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave));
    div_ratio_checker #(.DIV(8), .CNT_W(8), .TOL(1), .LOCK_COUNT(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave));

    always #5 clk = ~clk;

    // Reference: edge times in cycles; period = difference between consecutive edge pulses.
    int m_mode[NI];
    int m_last[NI];
    int m_run[NI];
    int m_period[NI];
    bit m_pv[NI];
    bit m_lock[NI];
    bit m_err[NI];
    int tol[NI] = '{0, 1};
    int cyc = 0;
    bit h[4];   // fdiv_in as seen at this edge and the three before

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_mode[i] = MIDLE; m_last[i] = 0; m_run[i] = 0; m_period[i] = 0;
            m_pv[i] = 1'b0; m_lock[i] = 1'b0; m_err[i] = 1'b0;
        end
        for (int k = 0; k < 4; k++) h[k] = 1'b0;
    endtask

    task automatic model_edge();
        bit e;
        bit ev;
        int p;
        cyc++;
        for (int k = 3; k > 0; k--) h[k] = h[k-1];
        h[0] = fdiv;
        // Edge pulse acts on the 3rd clk edge after fdiv_in rises.
        e = h[2] && !h[3];
        for (int i = 0; i < NI; i++) begin
            m_pv[i] = 1'b0;
            ev = 1'b0;
            if (!en) begin
                m_mode[i] = MIDLE; m_lock[i] = 1'b0; m_run[i] = 0;
            end else if (m_mode[i] == MIDLE) begin
                m_mode[i] = MACQ;
            end else if (m_mode[i] == MACQ) begin
                if (e) begin m_last[i] = cyc; m_mode[i] = MMEAS; end
            end else if (e) begin
                p = cyc - m_last[i];
                m_last[i] = cyc; m_period[i] = p; m_pv[i] = 1'b1;
                if (p != MAXC && p >= 8 - tol[i] && p <= 8 + tol[i]) begin
                    if (m_run[i] < 4) m_run[i]++;
                    m_lock[i] = (m_run[i] == 4);
                end else begin
                    m_run[i] = 0; m_lock[i] = 1'b0; ev = 1'b1;
                end
            end else if (cyc - m_last[i] == MAXC) begin
                m_period[i] = MAXC; m_pv[i] = 1'b1; m_run[i] = 0;
                m_lock[i] = 1'b0; ev = 1'b1; m_mode[i] = MACQ;
            end
            m_err[i] = STICKY ? (en && (m_err[i] || ev)) : ev;
        end
    endtask

    task automatic cmp_inst(input int i, input logic [7:0] per, input logic pv,
                            input logic lk, input logic er);
        check_val($sformatf("u%0d_period", i), 32'(per), m_period[i]);
        check_val($sformatf("u%0d_period_valid", i), 32'(pv), 32'(m_pv[i]));
        check_val($sformatf("u%0d_locked", i), 32'(lk), 32'(m_lock[i]));
        check_val($sformatf("u%0d_error", i), 32'(er), 32'(m_err[i]));
    endtask

    task automatic compare_all();
        cmp_inst(0, bus0.period, bus0.period_valid, bus0.locked, bus0.error);
        cmp_inst(1, bus1.period, bus1.period_valid, bus1.locked, bus1.error);
    endtask

    task automatic tick(input logic f, input logic e_n);
        fdiv = f;
        en   = e_n;
        @(posedge clk);
        #1;
        if (!reset_n) model_reset();
        else model_edge();
        compare_all();
    endtask

    // One fdiv_in period of p clk (rising edges p apart); enable drops for one cycle at drop_at.
    task automatic gen_period(input int p, input int drop_at);
        for (int i = 0; i < p; i++)
            tick((i < (p + 1) / 2) ? 1'b1 : 1'b0, (i == drop_at) ? 1'b0 : 1'b1);
    endtask

    initial begin
        int r;
        int p;
        reset_n = 1'b0;
        fdiv    = 1'b0;
        en      = 1'b0;
        model_reset();
        repeat (3) tick(1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (2) tick(1'b0, 1'b0);

        repeat (10) gen_period(8, -1);
        gen_period(9, -1);
        repeat (6) gen_period(8, -1);
        repeat (6) begin gen_period(7, -1); gen_period(9, -1); end
        gen_period(10, -1);
        repeat (5) gen_period(8, -1);

        repeat (300) tick(1'b0, 1'b1);
        repeat (7) gen_period(8, -1);

        gen_period(255, -1);
        gen_period(254, -1);
        repeat (6) gen_period(8, -1);
        gen_period(8, 4);
        repeat (6) gen_period(8, -1);

        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 15));
            if (r < 9)       p = 8;
            else if (r < 11) p = 7;
            else if (r < 13) p = 9;
            else if (r < 14) p = 10;
            else             p = int'($urandom_range(2, 20));
            gen_period(p, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, p - 1)) : -1);
        end

        repeat (6) gen_period(8, -1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (3) tick(1'b0, 1'b1);
        reset_n = 1'b1;
        repeat (8) gen_period(8, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
